// File: rtl/midi_pkg.sv
// Shared MIDI link definitions: default bit divider and TX/RX FSM states.
// Imported by midi_link_ctrl and midi_rx_deser.
package midi_pkg;

  localparam int MIDI_CLK_DIV = 687;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_e;

endpackage

// File: rtl/midi_rx_deser.sv
// MIDI serial receiver: 2-flop synchronizer, start/data/stop FSM, shifter.
// Ports: clk, reset, midi_rx in; rx_data, rx_valid, rx_frame_err out.
module midi_rx_deser
  import midi_pkg::*;
#(
  parameter int CLK_DIV = MIDI_CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [11:0] TC      = 12'(CLK_DIV - 1);
  localparam logic [11:0] HALF_TC = 12'(CLK_DIV / 2 - 1);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic        prev_q;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  assign rx_s = sync_q[1];

  // Sync flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], midi_rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      // Half-bit wait lands later samples at mid-bit.
      R_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      R_DATA: begin
        if (cnt_q == TC) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      R_STOP: begin
        if (cnt_q == TC) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = R_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = R_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      R_BREAK: begin
        if (rx_s) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;

endmodule

// File: rtl/midi_link_ctrl.sv
// MIDI link controller: inline 8N1 transmitter plus midi_rx_deser receiver.
// Ports: tx_start/tx_data -> midi_tx, tx_busy, tx_done; midi_rx -> rx_*.
module midi_link_ctrl
  import midi_pkg::*;
#(
  parameter int CLK_DIV = MIDI_CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       midi_tx,
  input  logic       midi_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [11:0] TC = 12'(CLK_DIV - 1);

  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shreg_q, tx_shreg_d;
  logic        tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      T_IDLE: begin
        if (tx_start) begin
          tx_state_d = T_START;
          tx_cnt_d   = '0;
          tx_shreg_d = tx_data;
        end
      end
      T_START: begin
        if (tx_cnt_q == TC) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 12'd1;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == TC) begin
          tx_cnt_d = '0;
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = T_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 12'd1;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == TC) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
          tx_done_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 12'd1;
        end
      end
    endcase
  end

  always_comb begin
    midi_tx = 1'b1;
    unique case (tx_state_q)
      T_START: midi_tx = 1'b0;
      T_DATA:  midi_tx = tx_shreg_q[tx_idx_q];
      default: midi_tx = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state_q != T_IDLE);
  assign tx_done = tx_done_q;

  midi_rx_deser #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .midi_rx     (midi_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

endmodule

// File: tb/tb_midi_link_ctrl.sv
// Bench for midi_link_ctrl: scoreboarded TX/RX with a frame-level model.
// Second instance at the default divider checks a full-length frame.
module tb_midi_link_ctrl;

  localparam int CD  = 8;
  localparam int CD2 = 687;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_done, midi_tx;
  logic       midi_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;

  logic       tx_start2 = 1'b0;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_busy2, tx_done2, midi_tx2;
  logic       midi_rx2 = 1'b1;
  logic [7:0] rx_data2;
  logic       rx_valid2, rx_frame_err2;

  always #5 clk = ~clk;

  midi_link_ctrl #(.CLK_DIV(CD)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .midi_tx     (midi_tx),
    .midi_rx     (midi_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  midi_link_ctrl u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .tx_start    (tx_start2),
    .tx_data     (tx_data2),
    .tx_busy     (tx_busy2),
    .tx_done     (tx_done2),
    .midi_tx     (midi_tx2),
    .midi_rx     (midi_rx2),
    .rx_data     (rx_data2),
    .rx_valid    (rx_valid2),
    .rx_frame_err(rx_frame_err2)
  );

  typedef struct {
    logic [7:0] d;
    int         c;
  } tx_exp_t;

  typedef struct {
    bit         err;
    logic [7:0] d;
  } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int free_at = 0;
  int done_cnt = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame model: a start is taken only when the link is free; its done
  // pulse is seen 10 bit times plus one cycle after the request cycle.
  task automatic tx_pulse(input logic [7:0] d);
    tx_exp_t e;
    tx_start = 1'b1;
    tx_data  = d;
    if (cyc >= free_at) begin
      e.d = d;
      e.c = cyc + 10 * CD + 1;
      tx_q.push_back(e);
      free_at = e.c;
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic rx_level(input logic v, input int len);
    midi_rx = v;
    repeat (len) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit good);
    rx_exp_t e;
    e.err = !good;
    if (good) last_good = d;
    e.d = last_good;
    rx_q.push_back(e);
    rx_level(1'b0, CD);
    for (int i = 0; i < 8; i++) rx_level(d[i], CD);
    if (good) rx_level(1'b1, CD);
    else begin
      rx_level(1'b0, 40);
      rx_level(1'b1, 2 * CD);
    end
  endtask

  task automatic rx_glitch();
    rx_level(1'b0, 3);
    rx_level(1'b1, 2 * CD);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (tx_q.size() + rx_q.size()) != 0; i++)
      @(negedge clk);
    chk("drain", tx_q.size() + rx_q.size(), 0);
  endtask

  // TX monitor: decodes midi_tx independently of the DUT's state.
  bit         in_frame = 1'b0;
  int         n = 0;
  logic [9:0] bits = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame) n++;
      else if (!midi_tx) begin
        in_frame = 1'b1;
        n = 0;
        bits = '0;
      end
      if (in_frame && n % CD == CD / 2 && n / CD < 10)
        bits[n/CD] = midi_tx;
      if (in_frame && n == 5 * CD)
        chk("tx_busy_mid", int'(tx_busy), 1);
      if (tx_done) begin
        done_cnt++;
        chk("tx_done_expected", int'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) begin
          tx_exp_t e;
          e = tx_q.pop_front();
          chk("tx_done_cycle", cyc, e.c);
          chk("tx_byte", int'(bits[8:1]), int'(e.d));
          chk("tx_start_stop", int'({bits[9], bits[0]}), 2);
          chk("tx_frame_len", n, 10 * CD);
          chk("tx_busy_at_done", int'(tx_busy), 0);
        end
        in_frame = 1'b0;
      end
    end
  end

  // RX monitor
  always @(negedge clk) begin
    if (!reset && (rx_valid || rx_frame_err)) begin
      chk("rx_excl", int'(rx_valid && rx_frame_err), 0);
      chk("rx_event_expected", int'(rx_q.size() > 0), 1);
      if (rx_q.size() > 0) begin
        rx_exp_t e;
        e = rx_q.pop_front();
        chk("rx_kind", int'(rx_frame_err), int'(e.err));
        chk("rx_data", int'(rx_data), int'(e.d));
      end
    end
  end

  initial begin
    int dc;
    int c0;
    int m;
    bit got;
    logic [9:0] b2;

    repeat (4) @(negedge clk);
    chk("rst_midi_tx", int'(midi_tx), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_rx_flags", int'({rx_valid, rx_frame_err}), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_midi_tx", int'(midi_tx), 1);

    // A5 frame, ignored restart 20 cycles in, restart in the done cycle
    tx_pulse(8'hA5);
    repeat (19) @(negedge clk);
    tx_pulse(8'h11);
    while (cyc < free_at) @(negedge clk);
    tx_pulse(8'h3E);
    drain();

    // RX directed
    rx_frame(8'h90, 1'b1);
    rx_level(1'b1, 20);
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'h7F, 1'b1);
    rx_level(1'b1, 20);
    rx_glitch();
    rx_frame(8'hC6, 1'b0);
    rx_frame(8'h55, 1'b1);
    rx_level(1'b1, 20);
    drain();

    // Concurrent random traffic
    fork
      begin
        repeat (60) begin
          repeat ($urandom_range(1, 120)) @(negedge clk);
          tx_pulse(8'($urandom));
        end
      end
      begin
        repeat (25) begin
          m = $urandom_range(0, 9);
          if (m == 0) rx_glitch();
          else if (m == 1) rx_frame(8'($urandom), 1'b0);
          else rx_frame(8'($urandom), 1'b1);
          rx_level(1'b1, $urandom_range(0, 30));
        end
      end
    join
    drain();

    // Reset during frame bit 4
    tx_pulse(8'hC3);
    repeat (36) @(negedge clk);
    dc = done_cnt;
    reset = 1'b1;
    tx_q.delete();
    @(negedge clk);
    chk("rst_mid_midi_tx", int'(midi_tx), 1);
    chk("rst_mid_busy", int'(tx_busy), 0);
    reset = 1'b0;
    free_at = 0;
    last_good = 8'h00;
    repeat (100) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, dc);
    chk("rst_mid_idle", int'(midi_tx), 1);

    // Full-length frame at the default divider
    tx_start2 = 1'b1;
    tx_data2  = 8'hFE;
    c0 = cyc;
    @(negedge clk);
    tx_start2 = 1'b0;
    m = -1;
    b2 = '0;
    got = 1'b0;
    for (int i = 0; i < 8000 && !got; i++) begin
      if (m >= 0) m++;
      else if (!midi_tx2) m = 0;
      if (m >= 0 && m % CD2 == CD2 / 2 && m / CD2 < 10)
        b2[m/CD2] = midi_tx2;
      if (tx_done2) got = 1'b1;
      else @(negedge clk);
    end
    chk("d2_done_seen", int'(got), 1);
    chk("d2_frame_len", m, 10 * CD2);
    chk("d2_latency", cyc - c0, 10 * CD2 + 1);
    chk("d2_byte", int'(b2[8:1]), 8'hFE);
    chk("d2_start_stop", int'({b2[9], b2[0]}), 2);
    chk("d2_rx_idle", int'({rx_valid2, rx_frame_err2, rx_data2}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
